neuron_weight_ram: RTL and testbench

// - Parametrised 1R/1W synchronous weight/activation store for neuron layers; next-generation neuron RAM.
// - Adds registered read with valid strobe, write-first collision forwarding, and a built-in clear sequencer.
// - Sits between the layer controller (writes weights) and the MAC datapath (reads weights).

---
 rtl/neuron_pkg.sv | 13 +
 rtl/neuron_ram_clear_fsm.sv | 45 ++++
 rtl/neuron_weight_ram.sv | 102 ++++++++++
 tb/tb_neuron_weight_ram.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared defaults and clear-sequencer state encoding for the neuron weight RAM.
package neuron_pkg;

    localparam int NEURON_DATA_W = 8;
    localparam int NEURON_DEPTH  = 128;
    localparam int NEURON_ADDR_W = 8;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } clear_state_t;

endpackage

// File: rtl/neuron_ram_clear_fsm.sv
// Clear sequencer: sweeps every word once after reset or on clear_req, holding busy meanwhile.
module neuron_ram_clear_fsm
    import neuron_pkg::*;
#(
    parameter int DEPTH = NEURON_DEPTH,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_req,
    output logic             busy,
    output logic             clr_we,
    output logic [CNT_W-1:0] clr_addr
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    clear_state_t     state;
    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (state == ST_CLEAR) begin
            if (cnt == LAST) begin
                state <= ST_IDLE;
                cnt   <= '0;
                busy  <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (clear_req) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end
    end

    assign clr_we   = (state == ST_CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/neuron_weight_ram.sv
// 1R/1W weight store with registered read, write-first forwarding and clear sequencer.
// Define NEURON_RAM_PARITY_EN to store an even-parity bit per word and report par_err on reads.
module neuron_weight_ram
    import neuron_pkg::*;
#(
    parameter int                DATA_W    = NEURON_DATA_W,
    parameter int                DEPTH     = NEURON_DEPTH,
    parameter int                ADDR_W    = NEURON_ADDR_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              busy,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              par_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
`ifdef NEURON_RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef NEURON_RAM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    logic [MEM_W-1:0] mem [DEPTH];
    logic             clr_we;
    logic [IDX_W-1:0] clr_addr;
    logic             wr_ok;
    logic             rd_in_range;
    logic             collide;
    logic [MEM_W-1:0] rd_word;

    neuron_ram_clear_fsm #(
        .DEPTH (DEPTH),
        .CNT_W (IDX_W)
    ) u_fsm (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    assign wr_ok       = !busy && wr_en && ({1'b0, wr_addr} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_EXT);
    assign collide     = wr_ok && rd_in_range && (rd_addr == wr_addr);
    assign rd_word     = mem[rd_addr[IDX_W-1:0]];

    // NOTE: the array has no reset; the clear sequencer initialises it so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= encode(CLEAR_VAL);
        end else if (wr_ok) begin
            mem[wr_addr[IDX_W-1:0]] <= encode(wr_data);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            par_err  <= 1'b0;
        end else begin
            rd_valid <= rd_en && !busy;
            if (rd_en && !busy) begin
                if (!rd_in_range) begin
                    rd_data <= '0;
                    par_err <= 1'b0;
                end else if (collide) begin
                    // Forwarded data never went through the array, so it cannot carry a parity fault.
                    rd_data <= wr_data;
                    par_err <= 1'b0;
                end else begin
                    rd_data <= rd_word[DATA_W-1:0];
`ifdef NEURON_RAM_PARITY_EN
                    par_err <= ^rd_word;
`else
                    par_err <= 1'b0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_neuron_weight_ram.sv
// Scoreboard bench for neuron_weight_ram: directed stimulus pushes expectations, a monitor pops on rd_valid.
module tb_neuron_weight_ram;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear_req = 1'b0;
    logic       busy;
    logic       wr_en = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       rd_en = 1'b0;
    logic [7:0] rd_addr = '0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       par_err;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        int         cyc;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    neuron_weight_ram u_dut (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .busy      (busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: one expectation per rd_valid, checked for data, parity flag and 1-cycle latency.
    always begin
        @(posedge clk);
        #1;
        if (sb.size() != 0 && sb[0].cyc < cyc) begin
            check({"missing_valid_", sb[0].name}, 32'(rd_valid), 32'd1);
            void'(sb.pop_front());
        end else if (rd_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(rd_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({"data_", e.name}, 32'(rd_data), 32'(e.data));
                check({"perr_", e.name}, 32'(par_err), 32'(e.perr));
                check({"lat_", e.name}, cyc, e.cyc);
            end
        end
    end

    // Drive one cycle of port activity from a negedge; optionally expect a read result.
    task automatic step(input logic we, input logic [7:0] wa, input logic [7:0] wd,
                        input logic re, input logic [7:0] ra,
                        input logic [7:0] exp_d, input logic exp_p, input string nm);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = re;
        rd_addr = ra;
        if (re) sb.push_back('{exp_d, exp_p, cyc + 1, nm});
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("drain", sb.size(), 0);
    endtask

    // Count busy cycles while hammering reads (which must be ignored).
    task automatic count_busy(input string nm, input bit poke_clear);
        int n = 0;
        while (busy && n < 300) begin
            rd_en     = 1'b1;
            rd_addr   = 8'd10;
            clear_req = poke_clear && (n == 60);
            if (n % 32 == 0) check({nm, "_rd_valid_low"}, 32'(rd_valid), 32'd0);
            n++;
            @(negedge clk);
        end
        rd_en     = 1'b0;
        clear_req = 1'b0;
        check({nm, "_busy_cycles"}, n, 128);
    endtask

    initial begin
        idle(2);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_par_err", 32'(par_err), 32'd0);
        rst = 1'b0;
        count_busy("init", 1'b0);

        for (int a = 0; a < 128; a++) step(1'b0, 8'd0, 8'd0, 1'b1, 8'(a), 8'h00, 1'b0, "init_zero");
        drain();

        step(1'b1, 8'd3, 8'h5A, 1'b0, 8'd0, 8'h00, 1'b0, "");
        step(1'b0, 8'd0, 8'h00, 1'b1, 8'd3, 8'h5A, 1'b0, "rd3");
        step(1'b1, 8'd7, 8'hC3, 1'b1, 8'd7, 8'hC3, 1'b0, "collide7");
        step(1'b0, 8'd0, 8'h00, 1'b1, 8'd7, 8'hC3, 1'b0, "rd7_after");
        idle(1);
        check("hold_rd_data", 32'(rd_data), 32'hC3);
        check("hold_rd_valid", 32'(rd_valid), 32'd0);

        step(1'b1, 8'd1, 8'h01, 1'b0, 8'd0, 8'h00, 1'b0, "");
        step(1'b1, 8'd127, 8'h7E, 1'b1, 8'd3, 8'h5A, 1'b0, "b2b_3");
        step(1'b0, 8'd0, 8'h00, 1'b1, 8'd1, 8'h01, 1'b0, "b2b_1");
        step(1'b0, 8'd0, 8'h00, 1'b1, 8'd127, 8'h7E, 1'b0, "b2b_127");
        step(1'b1, 8'd200, 8'h11, 1'b0, 8'd0, 8'h00, 1'b0, "");
        step(1'b0, 8'd0, 8'h00, 1'b1, 8'd200, 8'h00, 1'b0, "rd200");
        step(1'b0, 8'd0, 8'h00, 1'b1, 8'd72, 8'h00, 1'b0, "rd72");
        step(1'b1, 8'd128, 8'h22, 1'b1, 8'd128, 8'h00, 1'b0, "collide_oob");
        step(1'b0, 8'd0, 8'h00, 1'b1, 8'd0, 8'h00, 1'b0, "rd0_after_oob");
        drain();

        step(1'b1, 8'd10, 8'hFF, 1'b0, 8'd0, 8'h00, 1'b0, "");
        step(1'b0, 8'd0, 8'h00, 1'b1, 8'd10, 8'hFF, 1'b0, "rd10_pre");
        drain();
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        count_busy("clear", 1'b1);
        check("clear_hold_rd_data", 32'(rd_data), 32'hFF);
        step(1'b0, 8'd0, 8'h00, 1'b1, 8'd10, 8'h00, 1'b0, "rd10_post");
        step(1'b0, 8'd0, 8'h00, 1'b1, 8'd3, 8'h00, 1'b0, "rd3_post");
        drain();

        step(1'b1, 8'd20, 8'hA5, 1'b0, 8'd0, 8'h00, 1'b0, "");
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        idle(40);
        rst = 1'b1;
        @(negedge clk);
        check("midclr_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        count_busy("midclr", 1'b0);
        step(1'b0, 8'd0, 8'h00, 1'b1, 8'd20, 8'h00, 1'b0, "rd20_post");
        drain();

`ifdef NEURON_RAM_PARITY_EN
        step(1'b1, 8'd5, 8'h33, 1'b0, 8'd0, 8'h00, 1'b0, "");
        step(1'b0, 8'd0, 8'h00, 1'b1, 8'd5, 8'h33, 1'b0, "rd5_clean");
        u_dut.mem[5][8] = ~u_dut.mem[5][8];
        step(1'b0, 8'd0, 8'h00, 1'b1, 8'd5, 8'h33, 1'b1, "rd5_flip");
        step(1'b1, 8'd5, 8'h34, 1'b1, 8'd5, 8'h34, 1'b0, "collide5");
        step(1'b0, 8'd0, 8'h00, 1'b1, 8'd5, 8'h34, 1'b0, "rd5_rewritten");
        drain();
`endif

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
